// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM state encoding and width limits.
package serial_adder_pkg;

    localparam int STATE_W   = 2;
    localparam int MAX_WIDTH = 32;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Operand and result handshakes of the serial adder.
// The master side is the producer/consumer; the slave side is the adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_full_adder.sv
// One-bit full-adder cell: the whole arithmetic datapath of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell with a registered carry resolves one bit per clock.
// Every output is a flop or a function of flops only, so nothing on the bus passes inputs straight through.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("serial_adder: WIDTH out of range 2..MAX_WIDTH");
    end

    state_e           state_r;
    state_e           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             carry_in_msb_r;
    logic             accept_s;
    logic             last_bit_s;
    logic             fa_sum_s;
    logic             fa_cout_s;

    full_adder u_fa (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and accept / last-bit strobes.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        last_bit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_s = 1'b1;
                    state_s  = ADD;
                end else begin
                    state_s  = IDLE;
                end
            end
            ADD: begin
                if (cnt_r == LAST_BIT) begin
                    last_bit_s = 1'b1;
                    state_s    = DONE;
                end else begin
                    state_s    = ADD;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand/sum shift registers, bit counter and carry chain; all quiet outside accept and ADD.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r         <= {WIDTH{1'b0}};
            b_sh_r         <= {WIDTH{1'b0}};
            sum_sh_r       <= {WIDTH{1'b0}};
            cnt_r          <= {CNT_W{1'b0}};
            carry_r        <= 1'b0;
            carry_in_msb_r <= 1'b0;
        end else if (accept_s) begin
            a_sh_r         <= bus.a;
            b_sh_r         <= bus.b;
            sum_sh_r       <= {WIDTH{1'b0}};
            cnt_r          <= {CNT_W{1'b0}};
            carry_r        <= bus.cin;
            carry_in_msb_r <= 1'b0;
        end else if (state_r == ADD) begin
            a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
            sum_sh_r <= {fa_sum_s, sum_sh_r[WIDTH-1:1]};
            carry_r  <= fa_cout_s;
            if (last_bit_s) begin
                // Counter parks on the last bit instead of wrapping; accept clears it.
                carry_in_msb_r <= carry_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.sum       = sum_sh_r;
    assign bus.cout      = carry_r;
    assign bus.ovf       = carry_in_msb_r ^ carry_r;

endmodule
